// File: rtl/sized_data_memory.sv
// Sized data memory: byte/half/word/double loads and stores into a word-wide RAM,
// with a fixed access latency, alignment/range checking and a valid/ready response.
`timescale 1ns/1ps
module sized_data_memory #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned MEM_BITS   = 10,
   parameter int unsigned LATENCY    = 1
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_write,
   input  logic [1:0]            req_size,
   input  logic                  req_unsigned,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic                  rsp_error
);

   localparam int unsigned BYTES = DATA_WIDTH / 8;
   localparam int unsigned OFF   = $clog2(BYTES);
   localparam int unsigned DEPTH = 1 << MEM_BITS;

   typedef enum logic [1:0] {StIdle, StWait, StResp} state_t;

   state_t                  state_q;
   logic [3:0]              count_q;
   logic                    cap_write_q;
   logic [1:0]              cap_size_q;
   logic                    cap_unsigned_q;
   logic [ADDR_WIDTH-1:0]   cap_addr_q;
   logic [DATA_WIDTH-1:0]   cap_wdata_q;
   logic [DATA_WIDTH-1:0]   rsp_rdata_q;
   logic                    rsp_error_q;

   // Contents start at zero and are deliberately untouched by reset.
   logic [DATA_WIDTH-1:0]   mem [DEPTH] = '{default: '0};

   logic                    accept;
   logic                    sel_write;
   logic [1:0]              sel_size;
   logic                    sel_unsigned;
   logic [ADDR_WIDTH-1:0]   sel_addr;
   logic [DATA_WIDTH-1:0]   sel_wdata;
   logic [MEM_BITS-1:0]     idx;
   logic [OFF-1:0]          lane;
   int                      lane_i;
   int                      nbytes;
   int                      nbits;
   logic                    size_err;
   logic                    align_err;
   logic                    range_err;
   logic                    req_err;
   logic                    do_access;
   logic                    mem_we;
   logic [BYTES-1:0]        byte_en;
   logic [DATA_WIDTH-1:0]   wdata_sh;
   logic [DATA_WIDTH-1:0]   rd_shift;
   logic                    msb;
   logic [DATA_WIDTH-1:0]   load_val;

   assign req_ready = (state_q == StIdle);
   assign rsp_valid = (state_q == StResp);
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_error = rsp_error_q;
   assign accept    = req_valid && (state_q == StIdle);

   // Live request fields while idle (zero-latency path), captured copy otherwise.
   always_comb begin
      if (state_q == StIdle) begin
         sel_write    = req_write;
         sel_size     = req_size;
         sel_unsigned = req_unsigned;
         sel_addr     = req_addr;
         sel_wdata    = req_wdata;
      end else begin
         sel_write    = cap_write_q;
         sel_size     = cap_size_q;
         sel_unsigned = cap_unsigned_q;
         sel_addr     = cap_addr_q;
         sel_wdata    = cap_wdata_q;
      end
   end

   assign idx    = sel_addr[MEM_BITS+OFF-1:OFF];
   assign lane   = sel_addr[OFF-1:0];
   assign lane_i = int'(lane);

   // Reject oversize, misaligned and out-of-range requests.
   always_comb begin
      size_err  = (32'd1 << sel_size) > BYTES;
      align_err = 1'b0;
      for (int i = 0; i < 3; i++) begin
         if ((i < int'(sel_size)) && sel_addr[i]) align_err = 1'b1;
      end
      range_err = (sel_addr >> (MEM_BITS + OFF)) != '0;
      req_err   = size_err | align_err | range_err;
   end

   assign do_access = (accept && !req_err && (LATENCY == 0)) ||
                      ((state_q == StWait) && (count_q == 4'd1));
   assign mem_we    = do_access && sel_write;

   // Byte enables and lane-aligned store data for the addressed word.
   always_comb begin
      nbytes   = 1 << sel_size;
      wdata_sh = sel_wdata << {lane, 3'b000};
      for (int k = 0; k < int'(BYTES); k++) begin
         byte_en[k] = (k >= lane_i) && (k < lane_i + nbytes);
      end
   end

   // Shift the addressed bytes down to bit 0 and sign- or zero-extend.
   always_comb begin
      rd_shift = mem[idx] >> {lane, 3'b000};
      nbits    = 8 << sel_size;
      if (nbits > int'(DATA_WIDTH)) nbits = int'(DATA_WIDTH);
      msb = 1'b0;
      for (int i = 0; i < int'(DATA_WIDTH); i++) begin
         if (i == nbits - 1) msb = rd_shift[i];
      end
      for (int i = 0; i < int'(DATA_WIDTH); i++) begin
         load_val[i] = (i < nbits) ? rd_shift[i] : (msb & ~sel_unsigned);
      end
   end

   // Byte-masked RAM write; the enable is derived from state so reset cancels it.
   always_ff @(posedge clock) begin
      if (mem_we) begin
         for (int k = 0; k < int'(BYTES); k++) begin
            if (byte_en[k]) mem[idx][k*8 +: 8] <= wdata_sh[k*8 +: 8];
         end
      end
   end

   // Request/wait/response sequencing with registered response outputs.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q        <= StIdle;
         count_q        <= '0;
         cap_write_q    <= 1'b0;
         cap_size_q     <= '0;
         cap_unsigned_q <= 1'b0;
         cap_addr_q     <= '0;
         cap_wdata_q    <= '0;
         rsp_rdata_q    <= '0;
         rsp_error_q    <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (req_valid) begin
                  cap_write_q    <= req_write;
                  cap_size_q     <= req_size;
                  cap_unsigned_q <= req_unsigned;
                  cap_addr_q     <= req_addr;
                  cap_wdata_q    <= req_wdata;
                  if (req_err) begin
                     state_q     <= StResp;
                     rsp_error_q <= 1'b1;
                     rsp_rdata_q <= '0;
                  end else if (LATENCY == 0) begin
                     state_q     <= StResp;
                     rsp_error_q <= 1'b0;
                     rsp_rdata_q <= req_write ? '0 : load_val;
                  end else begin
                     state_q <= StWait;
                     count_q <= 4'(LATENCY);
                  end
               end
            end
            StWait: begin
               if (count_q == 4'd1) begin
                  state_q     <= StResp;
                  count_q     <= '0;
                  rsp_error_q <= 1'b0;
                  rsp_rdata_q <= cap_write_q ? '0 : load_val;
               end else begin
                  count_q <= count_q - 4'd1;
               end
            end
            StResp: begin
               if (rsp_ready) begin
                  state_q     <= StIdle;
                  rsp_rdata_q <= '0;
                  rsp_error_q <= 1'b0;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_sized_data_memory.sv
// Directed bench for sized_data_memory: a 32-bit LATENCY=1 instance, a 32-bit
// LATENCY=0 instance and a 64-bit LATENCY=1 instance share the stimulus bus.
`timescale 1ns/1ps
module tb_sized_data_memory;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid;
   logic        req_write;
   logic        req_unsigned;
   logic        rsp_ready;
   logic [1:0]  req_size;
   logic [31:0] req_addr;
   logic [63:0] req_wdata;
   int          sel;
   logic [2:0]  rdy;
   logic [2:0]  rv;
   logic [2:0]  er;
   logic [31:0] rd0;
   logic [31:0] rd1;
   logic [63:0] rd2;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   sized_data_memory #(.DATA_WIDTH(32), .LATENCY(1)) u_w32_l1 (
      .clock(clk), .reset_n(rst_n), .req_valid(req_valid && (sel == 0)), .req_ready(rdy[0]),
      .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
      .req_addr(req_addr), .req_wdata(req_wdata[31:0]), .rsp_valid(rv[0]),
      .rsp_ready(rsp_ready), .rsp_rdata(rd0), .rsp_error(er[0])
   );

   sized_data_memory #(.DATA_WIDTH(32), .LATENCY(0)) u_w32_l0 (
      .clock(clk), .reset_n(rst_n), .req_valid(req_valid && (sel == 1)), .req_ready(rdy[1]),
      .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
      .req_addr(req_addr), .req_wdata(req_wdata[31:0]), .rsp_valid(rv[1]),
      .rsp_ready(rsp_ready), .rsp_rdata(rd1), .rsp_error(er[1])
   );

   sized_data_memory #(.DATA_WIDTH(64), .LATENCY(1)) u_w64_l1 (
      .clock(clk), .reset_n(rst_n), .req_valid(req_valid && (sel == 2)), .req_ready(rdy[2]),
      .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
      .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rv[2]),
      .rsp_ready(rsp_ready), .rsp_rdata(rd2), .rsp_error(er[2])
   );

   typedef struct {
      int          inst;
      logic        w;
      logic [1:0]  sz;
      logic        un;
      logic [31:0] addr;
      logic [63:0] wd;
      logic [63:0] exp_rd;
      logic        exp_er;
      int          exp_lat;
      string       name;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   // Present one request for exactly one accept edge, then scramble the bus.
   task automatic issue(input int inst, input logic w, input logic [1:0] sz, input logic un,
                        input logic [31:0] a, input logic [63:0] wd);
      sel = inst;
      @(negedge clk);
      check("req_ready_before_issue", 64'(rdy[inst]), 64'd1);
      req_valid    = 1'b1;
      req_write    = w;
      req_size     = sz;
      req_unsigned = un;
      req_addr     = a;
      req_wdata    = wd;
      @(negedge clk);
      req_valid    = 1'b0;
      req_write    = ~w;
      req_size     = ~sz;
      req_unsigned = ~un;
      req_addr     = ~a;
      req_wdata    = ~wd;
   endtask

   // Cycles from accept to rsp_valid; -1 if the response never arrives.
   task automatic wait_rsp(input int inst, output int lat);
      lat = 1;
      while (!rv[inst] && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      if (!rv[inst]) lat = -1;
   endtask

   function automatic logic [63:0] cur_rdata(input int inst);
      if (inst == 2) return rd2;
      if (inst == 1) return {32'h0, rd1};
      return {32'h0, rd0};
   endfunction

   task automatic pulse_reset();
      #1 rst_n = 1'b0;
      #1;
   endtask

   initial begin
      int          lat;
      logic [63:0] rd;
      logic        e;

      rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = '0; req_unsigned = 1'b0;
      req_addr = '0; req_wdata = '0; rsp_ready = 1'b0; sel = 0;
      #2;
      check("reset_rsp_valid", 64'(rv), 64'd0);
      check("reset_rsp_error", 64'(er), 64'd0);
      check("reset_rsp_rdata", rd0, 64'd0);
      #10 rst_n = 1'b1;
      @(negedge clk);
      check("reset_req_ready", 64'(rdy), 64'h7);

      //                inst w  sz un addr           wdata                  exp rdata              err lat
      vecs.push_back('{0, 1, 2, 0, 32'h10,       64'hDEADBEEF,          64'h0,                 0, 2, "st_w_10"});
      vecs.push_back('{0, 0, 2, 0, 32'h10,       64'h0,                 64'hDEADBEEF,          0, 2, "ld_w_10"});
      vecs.push_back('{0, 1, 0, 0, 32'h13,       64'h12345680,          64'h0,                 0, 2, "st_b_13"});
      vecs.push_back('{0, 0, 0, 0, 32'h13,       64'h0,                 64'hFFFFFF80,          0, 2, "ld_sb_13"});
      vecs.push_back('{0, 0, 0, 1, 32'h13,       64'h0,                 64'h00000080,          0, 2, "ld_ub_13"});
      vecs.push_back('{0, 0, 2, 0, 32'h10,       64'h0,                 64'h80ADBEEF,          0, 2, "ld_w_merged"});
      vecs.push_back('{0, 1, 1, 0, 32'h13,       64'hAAAA,              64'h0,                 1, 1, "st_h_misaligned"});
      vecs.push_back('{0, 0, 2, 0, 32'h10,       64'h0,                 64'h80ADBEEF,          0, 2, "ld_w_after_err"});
      vecs.push_back('{0, 1, 2, 0, 32'h1000,     64'h11111111,          64'h0,                 1, 1, "st_out_of_range"});
      vecs.push_back('{0, 0, 2, 0, 32'h0,        64'h0,                 64'h0,                 0, 2, "ld_w_0_no_alias"});
      vecs.push_back('{0, 0, 3, 0, 32'h10,       64'h0,                 64'h0,                 1, 1, "ld_double_on_32"});
      vecs.push_back('{0, 0, 2, 0, 32'h80000010, 64'h0,                 64'h0,                 1, 1, "ld_high_addr"});
      vecs.push_back('{0, 0, 2, 1, 32'h12,       64'h0,                 64'h0,                 1, 1, "ld_w_misaligned"});
      vecs.push_back('{0, 1, 1, 0, 32'h12,       64'h12348001,          64'h0,                 0, 2, "st_h_12"});
      vecs.push_back('{0, 0, 1, 0, 32'h12,       64'h0,                 64'hFFFF8001,          0, 2, "ld_sh_12"});
      vecs.push_back('{0, 0, 1, 1, 32'h12,       64'h0,                 64'h00008001,          0, 2, "ld_uh_12"});
      vecs.push_back('{0, 0, 2, 0, 32'h10,       64'h0,                 64'h8001BEEF,          0, 2, "ld_w_after_half"});
      vecs.push_back('{0, 0, 0, 0, 32'h11,       64'h0,                 64'hFFFFFFBE,          0, 2, "ld_sb_11"});
      vecs.push_back('{0, 0, 1, 1, 32'h10,       64'h0,                 64'h0000BEEF,          0, 2, "ld_uh_10"});
      vecs.push_back('{0, 0, 2, 1, 32'h10,       64'h0,                 64'h8001BEEF,          0, 2, "ld_w_unsigned"});
      vecs.push_back('{1, 1, 2, 0, 32'h10,       64'hDEADBEEF,          64'h0,                 0, 1, "l0_st_w_10"});
      vecs.push_back('{1, 0, 2, 0, 32'h10,       64'h0,                 64'hDEADBEEF,          0, 1, "l0_ld_w_10"});
      vecs.push_back('{1, 1, 1, 0, 32'h11,       64'h1234,              64'h0,                 1, 1, "l0_st_h_misaligned"});
      vecs.push_back('{2, 1, 3, 0, 32'h18,       64'h0123456789ABCDEF,  64'h0,                 0, 2, "w64_st_d_18"});
      vecs.push_back('{2, 0, 3, 0, 32'h18,       64'h0,                 64'h0123456789ABCDEF,  0, 2, "w64_ld_d_18"});
      vecs.push_back('{2, 0, 2, 0, 32'h1C,       64'h0,                 64'h0000000001234567,  0, 2, "w64_ld_sw_1c"});
      vecs.push_back('{2, 0, 2, 0, 32'h18,       64'h0,                 64'hFFFFFFFF89ABCDEF,  0, 2, "w64_ld_sw_18"});
      vecs.push_back('{2, 0, 0, 0, 32'h18,       64'h0,                 64'hFFFFFFFFFFFFFFEF,  0, 2, "w64_ld_sb_18"});
      vecs.push_back('{2, 0, 1, 1, 32'h1A,       64'h0,                 64'h00000000000089AB,  0, 2, "w64_ld_uh_1a"});
      vecs.push_back('{2, 0, 3, 0, 32'h1C,       64'h0,                 64'h0,                 1, 1, "w64_ld_d_misaligned"});

      for (int i = 0; i < vecs.size(); i++) begin
         issue(vecs[i].inst, vecs[i].w, vecs[i].sz, vecs[i].un, vecs[i].addr, vecs[i].wd);
         wait_rsp(vecs[i].inst, lat);
         rd = cur_rdata(vecs[i].inst);
         e  = er[vecs[i].inst];
         check({vecs[i].name, "_latency"}, 64'(lat), 64'(vecs[i].exp_lat));
         check({vecs[i].name, "_rdata"}, rd, vecs[i].exp_rd);
         check({vecs[i].name, "_error"}, 64'(e), 64'(vecs[i].exp_er));
         rsp_ready = 1'b1;
         @(negedge clk);
         rsp_ready = 1'b0;
         check({vecs[i].name, "_idle_after"}, 64'({rv[vecs[i].inst], rdy[vecs[i].inst]}), 64'b01);
      end

      // Response held under back-pressure stays stable and blocks new requests.
      issue(0, 1'b0, 2'd2, 1'b0, 32'h10, 64'h0);
      wait_rsp(0, lat);
      check("hold_latency", 64'(lat), 64'd2);
      for (int c = 0; c < 5; c++) begin
         check("hold_rsp_valid", 64'(rv[0]), 64'd1);
         check("hold_rdata", rd0, 64'h8001BEEF);
         check("hold_req_ready", 64'(rdy[0]), 64'd0);
         @(negedge clk);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      check("hold_release_valid", 64'(rv[0]), 64'd0);
      check("hold_release_ready", 64'(rdy[0]), 64'd1);

      // Reset during WAIT cancels the store.
      issue(0, 1'b1, 2'd2, 1'b0, 32'h20, 64'h11223344);
      wait_rsp(0, lat);
      rsp_ready = 1'b1; @(negedge clk); rsp_ready = 1'b0;
      issue(0, 1'b1, 2'd2, 1'b0, 32'h20, 64'h55667788);
      check("wait_req_ready_low", 64'(rdy[0]), 64'd0);
      pulse_reset();
      check("wait_reset_valid", 64'(rv[0]), 64'd0);
      check("wait_reset_ready", 64'(rdy[0]), 64'd1);
      #1 rst_n = 1'b1;
      issue(0, 1'b0, 2'd2, 1'b0, 32'h20, 64'h0);
      wait_rsp(0, lat);
      check("wait_reset_ld_20", rd0, 64'h11223344);
      rsp_ready = 1'b1; @(negedge clk); rsp_ready = 1'b0;

      // Reset during RESP drops the response but keeps a completed store.
      issue(0, 1'b1, 2'd2, 1'b0, 32'h24, 64'h99);
      wait_rsp(0, lat);
      check("resp_store_valid", 64'(rv[0]), 64'd1);
      pulse_reset();
      check("resp_reset_valid", 64'(rv[0]), 64'd0);
      #1 rst_n = 1'b1;
      issue(0, 1'b0, 2'd2, 1'b0, 32'h24, 64'h0);
      wait_rsp(0, lat);
      check("resp_reset_ld_24", rd0, 64'h99);
      pulse_reset();
      check("resp_reset_rdata_clear", rd0, 64'h0);
      #1 rst_n = 1'b1;
      issue(0, 1'b0, 2'd3, 1'b0, 32'h10, 64'h0);
      wait_rsp(0, lat);
      check("resp_err_set", 64'(er[0]), 64'd1);
      pulse_reset();
      check("resp_reset_error_clear", 64'(er[0]), 64'd0);
      #1 rst_n = 1'b1;

      @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
